control_cmd_writespan: RTL
==========================

# control_cmd_writespan

Command-payload engine for the LED display's serial control path. It is the multi-pixel successor to the single-pixel write command. It takes one byte per `enable` strobe from the command decoder: a row, a column start, a span length/mode byte, then payload. It issues framebuffer RAM writes across consecutive columns. Fill mode replicates one pixel across the span autonomously.

## Interface
- `BYTES_PER_PIXEL`, `params_pkg::BYTES_PER_PIXEL`: bytes per pixel, at least 1.
- `PIXEL_HEIGHT`, `params_pkg::PIXEL_HEIGHT`: panel rows.
- `PIXEL_WIDTH`, `params_pkg::PIXEL_WIDTH`: panel columns; column wrap point.
- `MAX_SPAN`, 128: largest span, in pixels; must be ≤128.
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-low
- `enable`  in  1  one-cycle strobe; `data_in` is valid in this cycle
- `data_in`  in  8  command byte
- `row`  out  RB = `calc_pkg::num_row_address_bits(PIXEL_HEIGHT)`  target row
- `column`  out  CB = `calc_pkg::num_column_address_bits(PIXEL_WIDTH)`  target column
- `pixel`  out  PB = `calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)`  byte lane within the pixel
- `data_out`  out  8  write data
- `ram_write_enable`  out  1  high throughout the payload and burst phases
- `ram_access_start`  out  1  toggles once per RAM write
- `busy`  out  1  high during a fill burst
- `dropped`  out  1  one-cycle pulse when an `enable` is ignored
- `done`  out  1  one-cycle pulse when the command completes

## Operation
- States and byte order:
  - `ROW`: captures `row` = `data_in[RB-1:0]`.
  - `COL`: takes COL_BYTES = ceil(CB/8) bytes, LSB first. The column is truncated to CB bits. A value ≥ `PIXEL_WIDTH` is replaced by 0.
  - `LEN`: bit 7 = fill flag. bits[6:0] = span−1, so the span is 1..128. The span is clamped to `MAX_SPAN`.
  - `PAYLOAD`: handles every data byte in normal mode. In fill mode it captures only the first `BYTES_PER_PIXEL` bytes into a pixel buffer.
  - `FILL`: burst state.
  - `DONE`: completion state.
- Normal mode:
  - Each payload byte produces one write.
  - `pixel` counts down from BPP−1 to 0 within each pixel.
  - After lane 0, `column` increments. It wraps from `PIXEL_WIDTH`−1 to 0; `row` is unchanged.
  - After span×BPP bytes, the block goes to `DONE`.
- Fill mode:
  - After the BPP-th buffered byte, the block enters `FILL` with `busy`=1.
  - It issues span×BPP writes, one per clk, from the buffer in the same lane and column order.
  - Then it goes to `DONE`.
- `DONE`: `done`=1 and `ram_write_enable`=0 for one cycle, then return to `ROW`. An `enable` in the `DONE` cycle is accepted as the next command's row byte.
- An `enable` while `busy` is ignored: the byte is dropped, `dropped` pulses, and the burst continues unaffected.
- Counters:
  - byte counter: 16 bits, compared against span×BPP.
  - span counter: 8 bits.
  - No arithmetic exceeds those widths when `MAX_SPAN`≤128 and BPP≤255.

## Timing
- Reset values of all outputs: 0. FSM in `ROW`. Counters and buffer cleared.
- Reset mid-command aborts with no further writes. The next `enable` after release is parsed as a row.
- Header latency: `row` and `column` are registered one clk after their strobe.
- Write latency: for a payload strobe at cycle N, in cycle N+1 `data_out`=byte, `pixel` and `column` are valid, and `ram_access_start` has toggled.
- `ram_write_enable` rises at the first write and stays high until `done`.
- Burst writes: one per clk. The first is one clk after the last buffered fill byte's strobe.
- `done`: the cycle after the final write.
- Throughput in normal mode is limited only by `enable` spacing; back-to-back strobes on consecutive clks are supported.

## Structure
- Add `writespan_cmd_t` (row, column, len/flag header) and `WRITESPAN_FILL_BIT`=7 to `commands_pkg`.
- Width functions come from the existing `calc_pkg`.
- FSM state enum stays local.
- One natural sub-module, `span_addr_gen`: lane/column/span counters with column wrap and a `last` flag. It is shared by the normal and fill paths.

## Test plan
- Single pixel, BPP=2, W=64: bytes 05,0A,00,AB,CD -> two writes at row 5, col 10: (pixel 1, AB) then (pixel 0, CD); `ram_access_start` toggles twice; one `done`.
- Wrap: 03,3E,02, then 6 bytes -> columns 62,62,63,63,0,0; `row` stays 3; `done` after the 6th write.
- Fill: 1F,00,83,12,34 -> 8 writes on consecutive clks (cols 0–3, lanes 1/0, data 12/34); `busy` high 8 cycles; one `done`.
- Strobe during fill -> `dropped` pulses once; the write sequence is identical to the previous test.
- Reset low mid-payload, after 1 of 2 bytes -> all outputs 0 immediately; a new 5-byte command after release completes correctly.
- Two commands back-to-back, second row byte in the `DONE` cycle -> both complete; `done` count = 2; column start 0x50 (≥64) is written to column 0.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - address and lane width helpers for the display control path
package calc_pkg;

  function automatic int addr_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int num_row_address_bits(input int pixel_height);
    return addr_bits(pixel_height);
  endfunction

  function automatic int num_column_address_bits(input int pixel_width);
    return addr_bits(pixel_width);
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return addr_bits(bytes_per_pixel);
  endfunction

endpackage

// File: rtl/commands_pkg.sv
// rtl/commands_pkg.sv - command header layouts for the serial control path
package commands_pkg;

  localparam int WRITESPAN_FILL_BIT = 7;

  typedef struct packed {
    logic [7:0]  row;
    logic [15:0] column;
    logic        fill;
    logic [6:0]  span_m1;
  } writespan_cmd_t;

endpackage

// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - panel geometry shared by the display control path
package params_pkg;

  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXEL_HEIGHT    = 32;
  localparam int PIXEL_WIDTH     = 64;

endpackage

// File: rtl/span_addr_gen.sv
// rtl/span_addr_gen.sv - lane/column/span walker shared by the normal and fill write paths
module span_addr_gen #(
  parameter int BPP   = 2,
  parameter int WIDTH = 64,
  parameter int CB    = 6,
  parameter int PB    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CB-1:0] i_col_start,
  input  logic [7:0]    i_span,
  input  logic          i_step,
  output logic [PB-1:0] o_lane,
  output logic [CB-1:0] o_col,
  output logic          o_last
);

  localparam logic [PB-1:0] LANE_TOP = PB'(BPP - 1);
  localparam logic [CB-1:0] COL_LAST = CB'(WIDTH - 1);

  logic [PB-1:0] r_lane;
  logic [CB-1:0] r_col;
  logic [7:0]    r_span_cnt;

  // Lanes count down inside a pixel; the column only advances after lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane     <= '0;
      r_col      <= '0;
      r_span_cnt <= '0;
    end else if (i_load) begin
      r_lane     <= LANE_TOP;
      r_col      <= i_col_start;
      r_span_cnt <= '0;
    end else if (i_step) begin
      if (r_lane == '0) begin
        r_lane     <= LANE_TOP;
        r_col      <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        r_span_cnt <= r_span_cnt + 8'd1;
      end else begin
        r_lane <= r_lane - 1'b1;
      end
    end
  end

  assign o_lane = r_lane;
  assign o_col  = r_col;
  assign o_last = (r_lane == '0) && (r_span_cnt == i_span - 8'd1);

endmodule

// File: rtl/control_cmd_writespan.sv
// rtl/control_cmd_writespan.sv - multi-pixel write-span command engine with autonomous fill bursts
module control_cmd_writespan
  import commands_pkg::*;
#(
  parameter int  BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int  PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int  PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter int  MAX_SPAN        = 128,
  localparam int RB = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int CB = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int PB = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    data_in,
  output logic [RB-1:0] row,
  output logic [CB-1:0] column,
  output logic [PB-1:0] pixel,
  output logic [7:0]    data_out,
  output logic          ram_write_enable,
  output logic          ram_access_start,
  output logic          busy,
  output logic          dropped,
  output logic          done
);

  localparam int             COL_BYTES    = (CB + 7) / 8;
  localparam int             CW           = COL_BYTES * 8;
  localparam logic [1:0]     COL_IDX_LAST = 2'(COL_BYTES - 1);
  localparam logic [15:0]    BUF_LAST     = 16'(BYTES_PER_PIXEL - 1);
  localparam logic [PB-1:0]  LANE_TOP     = PB'(BYTES_PER_PIXEL - 1);
  localparam logic [7:0]     SPAN_LIMIT   = 8'(MAX_SPAN);

  typedef enum logic [2:0] {S_ROW, S_COL, S_LEN, S_PAYLOAD, S_FILL, S_DONE} state_t;

  state_t        r_state, w_next_state;
  logic [RB-1:0] r_row;
  logic [CB-1:0] r_column;
  logic [PB-1:0] r_pixel;
  logic [7:0]    r_data_out;
  logic          r_we, r_ras, r_busy, r_dropped, r_done, r_fill;
  logic [CW-1:0] r_col_acc;
  logic [1:0]    r_col_idx;
  logic [7:0]    r_span;
  logic [15:0]   r_byte_cnt;
  logic [7:0]    r_buf [BYTES_PER_PIXEL];

  logic          w_accept, w_drop, w_write, w_gen_load, w_gen_step, w_gen_last;
  logic          w_cap_row, w_cap_col, w_cap_len, w_cap_buf, w_busy_set;
  logic [7:0]    w_write_data, w_fill_data, w_span_raw, w_span;
  logic [PB-1:0] w_gen_lane, w_buf_idx;
  logic [CB-1:0] w_gen_col, w_col_clean;
  logic [CW-1:0] w_col_full;

  assign w_drop   = enable && r_busy;
  assign w_accept = enable && !r_busy;

  // The range check uses the full assembled value so out-of-range starts map to column 0.
  assign w_col_full  = r_col_acc | (CW'(data_in) << (8 * r_col_idx));
  assign w_col_clean = (32'(w_col_full) >= 32'(PIXEL_WIDTH)) ? '0 : w_col_full[CB-1:0];

  assign w_span_raw = {1'b0, data_in[6:0]} + 8'd1;
  assign w_span     = (w_span_raw > SPAN_LIMIT) ? SPAN_LIMIT : w_span_raw;

  // Lane BPP-1 holds the first buffered byte; with BPP=1 the byte arriving now is the pixel.
  assign w_buf_idx   = LANE_TOP - w_gen_lane;
  assign w_fill_data = ((r_state == S_PAYLOAD) && (16'(w_buf_idx) == r_byte_cnt)) ?
                       data_in : r_buf[w_buf_idx];

  span_addr_gen #(
    .BPP  (BYTES_PER_PIXEL),
    .WIDTH(PIXEL_WIDTH),
    .CB   (CB),
    .PB   (PB)
  ) u_span_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_gen_load),
    .i_col_start(r_column),
    .i_span     (r_span),
    .i_step     (w_gen_step),
    .o_lane     (w_gen_lane),
    .o_col      (w_gen_col),
    .o_last     (w_gen_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_ROW;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_write_data = data_in;
    w_gen_load   = 1'b0;
    w_gen_step   = 1'b0;
    w_cap_row    = 1'b0;
    w_cap_col    = 1'b0;
    w_cap_len    = 1'b0;
    w_cap_buf    = 1'b0;
    w_busy_set   = 1'b0;
    case (r_state)
      S_ROW: if (w_accept) begin
        w_cap_row    = 1'b1;
        w_next_state = S_COL;
      end
      S_COL: if (w_accept) begin
        w_cap_col = 1'b1;
        if (r_col_idx == COL_IDX_LAST) w_next_state = S_LEN;
      end
      S_LEN: if (w_accept) begin
        w_cap_len    = 1'b1;
        w_gen_load   = 1'b1;
        w_next_state = S_PAYLOAD;
      end
      S_PAYLOAD: if (w_accept) begin
        if (!r_fill) begin
          w_write    = 1'b1;
          w_gen_step = 1'b1;
          if (w_gen_last) w_next_state = S_DONE;
        end else begin
          w_cap_buf = 1'b1;
          if (r_byte_cnt == BUF_LAST) begin
            w_write      = 1'b1;
            w_write_data = w_fill_data;
            w_gen_step   = 1'b1;
            w_busy_set   = 1'b1;
            w_next_state = w_gen_last ? S_DONE : S_FILL;
          end
        end
      end
      S_FILL: begin
        w_write      = 1'b1;
        w_write_data = w_fill_data;
        w_gen_step   = 1'b1;
        if (w_gen_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_ROW;
        if (w_accept) begin
          w_cap_row    = 1'b1;
          w_next_state = S_COL;
        end
      end
      default: w_next_state = S_ROW;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row      <= '0;
      r_column   <= '0;
      r_pixel    <= '0;
      r_data_out <= '0;
      r_we       <= 1'b0;
      r_ras      <= 1'b0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
      r_done     <= 1'b0;
      r_fill     <= 1'b0;
      r_col_acc  <= '0;
      r_col_idx  <= '0;
      r_span     <= '0;
      r_byte_cnt <= '0;
      for (int i = 0; i < BYTES_PER_PIXEL; i++) r_buf[i] <= '0;
    end else begin
      r_done    <= (r_state == S_DONE);
      r_dropped <= w_drop;
      if (w_cap_row) begin
        r_row     <= data_in[RB-1:0];
        r_col_acc <= '0;
        r_col_idx <= '0;
      end
      if (w_cap_col) begin
        r_col_acc <= w_col_full;
        if (r_col_idx == COL_IDX_LAST) begin
          r_column  <= w_col_clean;
          r_col_idx <= '0;
        end else begin
          r_col_idx <= r_col_idx + 2'd1;
        end
      end
      if (w_cap_len) begin
        r_fill     <= data_in[WRITESPAN_FILL_BIT];
        r_span     <= w_span;
        r_byte_cnt <= '0;
      end
      if (w_cap_buf) begin
        r_buf[r_byte_cnt[PB-1:0]] <= data_in;
        r_byte_cnt                <= r_byte_cnt + 16'd1;
      end
      if (w_write) begin
        r_data_out <= w_write_data;
        r_pixel    <= w_gen_lane;
        r_column   <= w_gen_col;
        r_ras      <= ~r_ras;
        r_we       <= 1'b1;
      end
      if (w_busy_set) r_busy <= 1'b1;
      if (r_state == S_DONE) begin
        r_we   <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end

  assign row              = r_row;
  assign column           = r_column;
  assign pixel            = r_pixel;
  assign data_out         = r_data_out;
  assign ram_write_enable = r_we;
  assign ram_access_start = r_ras;
  assign busy             = r_busy;
  assign dropped          = r_dropped;
  assign done             = r_done;

endmodule
